fir_coef_scheduler: RTL and testbench

- Configuration controller for the 33-tap FIR filter.
- Host writes coefficients into a shadow bank at any time; a commit pulse starts an update sequence.
- Update sequence: snapshot shadow into the active bank; hold the filter in reset so it latches the new coefficients; release and enable the filter; mask its output until the tap delay line holds only post-update samples.
- Sits between the register interface and the filter, driving the filter's reset_n, enable and coefficient inputs.

---
 rtl/fir_coef_scheduler.sv | 149 ++++++++++++++
 tb/tb_fir_coef_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_scheduler.sv
// Coefficient bank controller for the FIR filter: shadow/active banks and the update sequence
// that resets, reloads and warms up the filter after each commit.
module fir_coef_scheduler #(
  parameter int unsigned NTAPS       = 33,
  parameter int unsigned CW          = 32,
  parameter int unsigned AW          = 6,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned WARMUP      = 34
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [CW-1:0]         wr_data,
  input  logic                  commit,
  input  logic                  sample_valid,
  input  logic                  fir_valid_in,
  output logic [NTAPS*CW-1:0]   coef_bus,
  output logic                  fir_reset_n,
  output logic                  fir_enable,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  wr_err,
  output logic [7:0]            update_count
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCopy = 3'd1;
  localparam logic [2:0] StHold = 3'd2;
  localparam logic [2:0] StWarm = 3'd3;
  localparam logic [2:0] StRun  = 3'd4;

  localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);
  localparam bit          WarmZero = (WARMUP == 0);
  localparam logic [15:0] WarmLast = WarmZero ? 16'd0 : 16'(WARMUP - 1);

  logic [CW-1:0] shadow_q [NTAPS];
  logic [CW-1:0] active_q [NTAPS];

  logic [2:0]  state_q, state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [15:0] warm_cnt_q, warm_cnt_d;
  logic        pending_q, pending_d;
  logic [7:0]  upd_cnt_q, upd_cnt_d;
  logic        fir_reset_n_q, fir_enable_q, busy_q, wr_err_q;
  logic        load_active;
  logic        warm_done;
  logic        addr_bad;

  assign addr_bad  = {1'b0, wr_addr} >= (AW + 1)'(NTAPS);
  assign warm_done = WarmZero || (sample_valid && (warm_cnt_q == WarmLast));

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    pending_d   = pending_q;
    upd_cnt_d   = upd_cnt_q;
    load_active = 1'b0;
    case (state_q)
      StIdle, StRun: begin
        if (commit) state_d = StCopy;
      end
      StCopy: begin
        load_active = 1'b1;
        hold_cnt_d  = 16'd0;
        state_d     = StHold;
        if (commit) pending_d = 1'b1;
      end
      StHold: begin
        if (commit) pending_d = 1'b1;
        if (hold_cnt_q == HoldLast) begin
          state_d    = StWarm;
          warm_cnt_d = 16'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end
      StWarm: begin
        if (warm_done) begin
          upd_cnt_d  = upd_cnt_q + 8'd1;
          warm_cnt_d = 16'd0;
          // A commit landing on the exit cycle is treated as already pending.
          if (pending_q || commit) begin
            state_d   = StCopy;
            pending_d = 1'b0;
          end else begin
            state_d = StRun;
          end
        end else begin
          if (sample_valid) warm_cnt_d = warm_cnt_q + 16'd1;
          if (commit) pending_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      hold_cnt_q    <= 16'd0;
      warm_cnt_q    <= 16'd0;
      pending_q     <= 1'b0;
      upd_cnt_q     <= 8'd0;
      fir_reset_n_q <= 1'b0;
      fir_enable_q  <= 1'b0;
      busy_q        <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      warm_cnt_q    <= warm_cnt_d;
      pending_q     <= pending_d;
      upd_cnt_q     <= upd_cnt_d;
      // Control outputs are registered from the next state so they align with it.
      fir_reset_n_q <= (state_d == StWarm) || (state_d == StRun);
      fir_enable_q  <= (state_d == StWarm) || (state_d == StRun);
      busy_q        <= (state_d == StCopy) || (state_d == StHold) || (state_d == StWarm);
      wr_err_q      <= wr_en && addr_bad;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (wr_en && (wr_addr == AW'(k))) shadow_q[k] <= wr_data;
        if (load_active) active_q[k] <= shadow_q[k];
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_bus
    assign coef_bus[k*CW +: CW] = active_q[k];
  end

  assign fir_reset_n  = fir_reset_n_q;
  assign fir_enable   = fir_enable_q;
  assign busy         = busy_q;
  assign wr_err       = wr_err_q;
  assign update_count = upd_cnt_q;
  assign out_valid    = (state_q == StRun) && fir_valid_in;

endmodule

// File: tb/tb_fir_coef_scheduler.sv
// Randomized bench for fir_coef_scheduler against a countdown-based reference model.
module tb_fir_coef_scheduler;

  localparam int NTAPS = 33;
  localparam int CW    = 32;
  localparam int AW    = 6;
  localparam int HOLD  = 2;
  localparam int WARM  = 34;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [CW-1:0]       wr_data;
  logic                commit;
  logic                sample_valid;
  logic                fir_valid_in;
  logic [NTAPS*CW-1:0] coef_bus;
  logic                fir_reset_n;
  logic                fir_enable;
  logic                out_valid;
  logic                busy;
  logic                wr_err;
  logic [7:0]          update_count;

  always #5 clk = ~clk;

  fir_coef_scheduler #(
    .NTAPS(NTAPS), .CW(CW), .AW(AW), .HOLD_CYCLES(HOLD), .WARMUP(WARM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .sample_valid(sample_valid), .fir_valid_in(fir_valid_in),
    .coef_bus(coef_bus), .fir_reset_n(fir_reset_n), .fir_enable(fir_enable),
    .out_valid(out_valid), .busy(busy), .wr_err(wr_err), .update_count(update_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: reset_left counts the COPY+HOLD cycles still owed, mask_left the
  // samples still to be masked; the filter runs freely once both reach zero.
  logic [CW-1:0] m_shadow [NTAPS];
  logic [CW-1:0] m_active [NTAPS];
  bit            m_started, m_pending, m_wr_err;
  int            m_reset_left, m_mask_left, m_count;
  bit            rnd_wr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NTAPS; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_started = 0; m_pending = 0; m_wr_err = 0;
    m_reset_left = 0; m_mask_left = 0; m_count = 0;
  endtask

  function automatic bit m_busy();
    return (m_reset_left > 0) || (m_mask_left > 0);
  endfunction

  task automatic model_step();
    if (m_reset_left == HOLD + 1)
      for (int k = 0; k < NTAPS; k++) m_active[k] = m_shadow[k];
    if (!m_busy()) begin
      if (commit) begin
        m_started = 1; m_reset_left = HOLD + 1; m_mask_left = WARM;
      end
    end else if (m_reset_left > 0) begin
      m_reset_left--;
      if (commit) m_pending = 1;
    end else begin
      if (sample_valid) m_mask_left--;
      if (m_mask_left == 0) begin
        m_count = (m_count + 1) % 256;
        if (m_pending || commit) begin
          m_reset_left = HOLD + 1; m_mask_left = WARM; m_pending = 0;
        end
      end else if (commit) begin
        m_pending = 1;
      end
    end
    m_wr_err = wr_en && (int'(wr_addr) >= NTAPS);
    if (wr_en && int'(wr_addr) < NTAPS) m_shadow[wr_addr] = wr_data;
  endtask

  task automatic check_outputs();
    bit run;
    run = m_started && (m_reset_left == 0);
    check("fir_reset_n", fir_reset_n, run);
    check("fir_enable", fir_enable, run);
    check("busy", busy, m_busy());
    check("out_valid", out_valid, m_started && !m_busy() && fir_valid_in);
    check("wr_err", wr_err, m_wr_err);
    check("update_count", update_count, m_count);
    for (int k = 0; k < NTAPS; k++) check("coef_tap", coef_bus[k*CW +: CW], m_active[k]);
  endtask

  task automatic cycle(input logic we, input logic [AW-1:0] a, input logic [CW-1:0] d,
                       input logic cm, input logic sv, input logic fv);
    wr_en = we; wr_addr = a; wr_data = d; commit = cm; sample_valid = sv; fir_valid_in = fv;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rnd_cycle(input logic cm, input bit always_sv);
    cycle(rnd_wr && ($urandom_range(0, 9) == 0), AW'($urandom_range(0, 63)), $urandom, cm,
          always_sv ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_until_idle(input bit always_sv);
    int n;
    n = 0;
    while (m_busy() && n < 2000) begin
      rnd_cycle(1'b0, always_sv);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    wr_en = 0; wr_addr = '0; wr_data = '0; commit = 0; sample_valid = 0; fir_valid_in = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rnd_wr = 0;
    do_reset();

    // Program every tap to 0x800 and apply.
    for (int k = 0; k < NTAPS; k++) cycle(1'b1, AW'(k), 32'h0000_0800, 1'b0, 1'b0, 1'b1);
    rnd_cycle(1'b1, 1'b0);
    run_until_idle(1'b0);
    check("upd1", update_count, 8'd1);
    for (int k = 0; k < NTAPS; k++) check("tap_800", coef_bus[k*CW +: CW], 32'h0000_0800);

    // RUN pass-through with toggling filter valid.
    for (int i = 0; i < 100; i++) cycle(1'b0, '0, '0, 1'b0, 1'($urandom_range(0, 1)), 1'(i % 2));

    // Out-of-range writes are dropped.
    cycle(1'b1, 6'd33, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 6'd63, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    run_until_idle(1'b0);
    check("upd_oob", update_count, 8'd2);
    check("tap32_after_oob", coef_bus[32*CW +: CW], 32'h0000_0800);

    // Write coinciding with commit is captured.
    cycle(1'b1, 6'd5, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
    run_until_idle(1'b0);
    check("tap5_same_cycle", coef_bus[5*CW +: CW], 32'h0001_0000);

    // Commit during WARM queues exactly one more update.
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 6'd0, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
    check("tap0_not_yet", coef_bus[0 +: CW], 32'h0000_0800);
    while (m_reset_left > 0 || (WARM - m_mask_left) < 10) rnd_cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    run_until_idle(1'b0);
    check("upd_pending", update_count, 8'd5);
    check("tap0_second", coef_bus[0 +: CW], 32'hFFFF_0000);

    // Random traffic with random writes and commits.
    rnd_wr = 1;
    for (int i = 0; i < 600; i++) rnd_cycle(1'($urandom_range(0, 19) == 0), 1'b0);
    run_until_idle(1'b0);

    // Asynchronous reset in HOLD.
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    while (m_reset_left != HOLD) rnd_cycle(1'b0, 1'b0);
    #2;
    reset_n = 0;
    #1;
    check("arst_fir_reset_n", fir_reset_n, 1'b0);
    check("arst_fir_enable", fir_enable, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_count", update_count, 8'd0);
    check("arst_coef", coef_bus[0 +: 64], 64'd0);
    do_reset();

    // Update count wraps after 256 updates.
    rnd_wr = 0;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      run_until_idle(1'b1);
      if (i == 254) check("count_255", update_count, 8'd255);
    end
    check("count_wrap", update_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
